// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage feeding the execute ALU.
// Decodes OP/OP-IMM/LUI and holds results in a two-entry skid-buffered ID/EX register.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_rs1,
    output logic [31:0] ex_rs2,
    output logic [3:0]  ex_alu_ctrl,
    output logic        ex_unsigned,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_illegal
);

    localparam int unsigned N = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    typedef struct packed {
        logic [N-1:0] rs1;
        logic [N-1:0] rs2;
        logic [3:0]   ctrl;
        logic         uns;
        logic [4:0]   rd;
        logic         rw;
        logic         ill;
    } entry_t;

    localparam entry_t ENTRY_RST = '{rs1: '0, rs2: '0, ctrl: ALU_NOP, uns: 1'b0,
                                     rd: '0, rw: 1'b0, ill: 1'b0};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic   accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_ctrl = ALU_ADD;
            3'b001:  f3_ctrl = ALU_SLL;
            3'b010:  f3_ctrl = ALU_SLT;
            3'b011:  f3_ctrl = ALU_SLTU;
            3'b100:  f3_ctrl = ALU_XOR;
            3'b101:  f3_ctrl = ALU_SRL;
            3'b110:  f3_ctrl = ALU_OR;
            default: f3_ctrl = ALU_AND;
        endcase
    endfunction

    // Instruction decode into an issue entry.
    always_comb begin
        dec    = ENTRY_RST;
        dec.rd = instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.rs1 = rf_rdata1;
                dec.rs2 = rf_rdata2;
                if (funct7 == F7_BASE) begin
                    dec.ctrl = f3_ctrl(funct3);
                    dec.uns  = (funct3 == 3'b011);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.ctrl = ALU_SRA;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.rs1 = rf_rdata1;
                dec.rs2 = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b001: begin
                        dec.rs2 = {27'd0, instr[24:20]};
                        if (funct7 == F7_BASE) dec.ctrl = ALU_SLL;
                        else                   dec.ill  = 1'b1;
                    end
                    3'b101: begin
                        dec.rs2 = {27'd0, instr[24:20]};
                        if (funct7 == F7_BASE)     dec.ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.ctrl = ALU_SRA;
                        else                       dec.ill  = 1'b1;
                    end
                    default: begin
                        dec.ctrl = f3_ctrl(funct3);
                        dec.uns  = (funct3 == 3'b011);
                    end
                endcase
            end
            OPC_LUI: begin
                dec.rs1  = '0;
                dec.rs2  = {12'd0, instr[31:12]};
                dec.ctrl = ALU_LUI;
            end
            default: dec.ill = 1'b1;
        endcase
        // Illegal entries still issue but are neutralised for the ALU.
        if (dec.ill) begin
            dec.rs1  = '0;
            dec.rs2  = '0;
            dec.ctrl = ALU_NOP;
            dec.uns  = 1'b0;
        end
        dec.rw = !dec.ill && (dec.rd != 5'd0);
    end

    assign in_ready = (state_q != ST_FULL) && !rst;
    assign accept   = in_valid && in_ready;

    // Buffer next-state: head feeds EX, skid catches the entry accepted while stalled.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && ex_ready) begin
                    head_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_FULL;
                end else if (ex_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (ex_ready) begin
                    head_d  = skid_q;
                    skid_d  = ENTRY_RST;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            skid_d  = ENTRY_RST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign ex_valid     = (state_q != ST_EMPTY);
    assign ex_rs1       = head_q.rs1;
    assign ex_rs2       = head_q.rs2;
    assign ex_alu_ctrl  = head_q.ctrl;
    assign ex_unsigned  = head_q.uns;
    assign ex_rd        = head_q.rd;
    assign ex_reg_write = head_q.rw;
    assign ex_illegal   = head_q.ill;

endmodule
